// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for an 8x8 synchronous memory.
// Every transaction runs IDLE -> ISSUE -> WAIT -> RESP; all outputs come from registers.
module mem_rr_arbiter #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_enable,
    output logic              mem_rb_w,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_we;
    logic   r_owner_b;
    logic   r_last_b;
    logic   w_grant_b;

    // B wins when it is alone, or on a tie when A was served last.
    assign w_grant_b = b_req & (~a_req | ~r_last_b);

    // mem_address/mem_data_in double as the latched request and hold outside ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_owner_b   <= 1'b0;
            r_last_b    <= 1'b1;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            busy        <= 1'b0;
            rdata       <= '0;
            mem_enable  <= 1'b0;
            mem_rb_w    <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    if (a_req || b_req) begin
                        r_owner_b   <= w_grant_b;
                        r_last_b    <= w_grant_b;
                        r_we        <= w_grant_b ? b_we : a_we;
                        mem_rb_w    <= w_grant_b ? b_we : a_we;
                        mem_address <= w_grant_b ? b_addr : a_addr;
                        mem_data_in <= w_grant_b ? b_wdata : a_wdata;
                        mem_enable  <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_enable <= 1'b0;
                    mem_rb_w   <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (!r_we) begin
                        rdata <= mem_data_out;
                    end
                    a_ack   <= ~r_owner_b;
                    b_ack   <= r_owner_b;
                    r_state <= RESP;
                end
                RESP: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
